// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-4 Booth multiplier.
// Accepts one signed operand pair over a valid/ready handshake, adds one
// Booth partial product per clock into a 2*WIDTH accumulator and presents
// the signed product over a second valid/ready handshake.
module booth_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] mul,
    output logic               busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int STEPS = WIDTH / 2;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    // Odd or tiny widths would leave the top Booth digit malformed.
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("booth_mul_seq: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [SW-1:0]   step;
    logic [PW-1:0]   acc;
    // Multiplicand pre-shifted by 2*step so each partial product is
    // already aligned when it reaches the adder.
    logic [PW-1:0]   mcand;
    // {B,1'b0} shifted right by two per step; bits [2:0] are the current
    // Booth triple {B[2i+1], B[2i], B[2i-1]}.
    logic [WIDTH:0]  mplier;

    logic [PW-1:0]   mcand_x2;
    logic [PW-1:0]   pp;
    logic [PW-1:0]   sum;
    logic            last_step;

    // Handshake flags decode straight from state, never from in_valid/out_ready.
    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // Booth digit selection and the accumulator adder for the current step.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        pp       = '0;
        mcand_x2 = {mcand[PW-2:0], 1'b0};
        case (mplier[2:0])
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand_x2;
            3'b100:         pp = -mcand_x2;
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
        sum       = acc + pp;
        last_step = (step == SW'(STEPS - 1));
    end

    // Sequencer: IDLE accepts operands, RUN accumulates one digit per
    // cycle, DONE holds the product until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the operand registers are reset too, so a reset mid-RUN
        // leaves nothing from the discarded product behind.
        if (!rst_n) begin
            state     <= S_IDLE;
            step      <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            mul       <= '0;
            out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        mcand  <= {{WIDTH{A[WIDTH-1]}}, A};
                        mplier <= {B, 1'b0};
                        acc    <= '0;
                        step   <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc    <= sum;
                    mcand  <= {mcand[PW-3:0], 2'b00};
                    mplier <= {2'b00, mplier[WIDTH:2]};
                    step   <= step + SW'(1);
                    if (last_step) begin
                        mul       <= sum;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed corner cases plus randomized traffic with
// consumer stalls, checked against plain signed multiplication.
module tb_booth_mul_seq;

    localparam int W     = 16;
    localparam int NRAND = 1000;
    localparam int MAXC  = 60000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] mul;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    bit abort    = 1'b0;

    logic [2*W-1:0] exp_q[$];

    booth_mul_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .mul      (mul),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: exact signed product, wrapped to 2*W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        return (2*W)'(sa * sb);
    endfunction

    // Returns on a falling edge with in_ready high, or flags a timeout.
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("idle_timeout", 64'(in_ready), 64'd1);
            abort = 1'b1;
        end
    endtask

    // One directed operation: latency, product, optional consumer stall
    // with an ignored in_valid poke, then return to IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input int stall, input bit poke);
        logic [2*W-1:0] held;
        int lat;
        wait_idle();
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        check("busy_after_accept", 64'(busy), 64'd1);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", 64'(lat), 64'(W/2));
        check("product", 64'(mul), 64'(exp));
        held = mul;
        for (int i = 0; i < stall; i++) begin
            if (poke && i == 1) begin
                in_valid = 1'b1;
                A = 16'd7;
                B = 16'd7;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_hold", 64'(mul), 64'(held));
            check("stall_not_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", 64'(out_valid), 64'd0);
        check("back_idle", 64'(in_ready), 64'd1);
        if (poke) begin
            @(posedge clk); #1;
            check("poke_ignored", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_mul", 64'(mul), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corners, including most-negative operands and all-ones B.
        run_op(16'd3,     16'd5,     32'h0000000F, 0, 1'b0);
        run_op(16'h8000,  16'h8000,  32'h40000000, 0, 1'b0);
        run_op(16'h7FFF,  16'h8000,  32'hC0008000, 0, 1'b0);
        run_op(16'hFFFF,  16'h7FFF,  32'hFFFF8001, 0, 1'b0);
        run_op(16'd0,     16'hFFFF,  32'h00000000, 0, 1'b0);
        run_op(16'd100,   16'hFFFD,  32'hFFFFFED4, 5, 1'b1);

        // Reset in the middle of RUN discards the product.
        wait_idle();
        in_valid  = 1'b1;
        A         = 16'd1234;
        B         = 16'hFFFB;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_valid", 64'(out_valid), 64'd0);
        check("midrun_rst_mul", 64'(mul), 64'd0);
        check("midrun_rst_ready", 64'(in_ready), 64'd1);
        check("midrun_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_ghost_product", 64'(seen), 64'd0);
        out_ready = 1'b0;
        run_op(16'hFFF9, 16'd6, 32'hFFFFFFD6, 0, 1'b0);

        // Random traffic: producer with gaps, consumer with random stalls.
        fork
            begin : driver
                logic [W-1:0] ra, rb;
                for (int k = 0; k < NRAND && !abort; k++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    wait_idle();
                    if (abort) break;
                    ra = W'($urandom);
                    rb = W'($urandom);
                    exp_q.push_back(ref_mul(ra, rb));
                    in_valid = 1'b1;
                    A = ra;
                    B = rb;
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                    A = W'($urandom);
                    B = W'($urandom);
                end
            end
            begin : monitor
                int received = 0;
                int cyc = 0;
                bit pending = 1'b0;
                logic [2*W-1:0] prev = '0;
                while (received < NRAND && cyc < MAXC && !abort) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid) begin
                        if (pending) check("rand_hold", 64'(mul), 64'(prev));
                        if (out_ready) begin
                            if (exp_q.size() == 0) check("rand_spurious", 64'd1, 64'd0);
                            else check("rand_product", 64'(mul), 64'(exp_q.pop_front()));
                            received++;
                            pending = 1'b0;
                        end else begin
                            pending = 1'b1;
                            prev    = mul;
                        end
                    end else if (pending) begin
                        check("rand_withdrawn", 64'(out_valid), 64'd1);
                        pending = 1'b0;
                    end
                end
                check("rand_count", 64'(received), 64'(NRAND));
                out_ready = 1'b0;
            end
        join
        check("rand_leftover", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
